// File: rtl/mod3_stream_tx_if.sv
// Word-in / bit-out link bundle for the mod-3 residue serializer.
// The producer drives the word side; the serializer drives the line side.
interface mod3_stream_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              bit_out;
    logic              bit_valid;
    logic              frame_start;
    logic              frame_end;

    modport master (
        output in_valid, in_data,
        input  in_ready, bit_out, bit_valid, frame_start, frame_end
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, bit_out, bit_valid, frame_start, frame_end
    );
endinterface

// File: rtl/mod3_stream_tx.sv
// Serializes a word MSB-first and appends two check bits so that
// every (DATA_W+2)-bit frame is an exact multiple of 3.
module mod3_stream_tx #(
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    mod3_stream_tx_if.slave  link
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CHK
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        r_q, r_d;
    logic              bit_q, bit_d;
    logic              vld_q, vld_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              ready;
    logic              accept;
    logic [1:0]        chk;

    // Residue of (2r + b) mod 3; the unused encoding falls back to 0.
    function automatic logic [1:0] res_step(input logic [1:0] r,
                                            input logic       b);
        logic [1:0] n;
        case (r)
            2'd0:    n = b ? 2'd1 : 2'd0;
            2'd1:    n = b ? 2'd0 : 2'd2;
            2'd2:    n = b ? 2'd2 : 2'd1;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // c chosen so that (4*D + c) mod 3 == 0, with 4 == 1 mod 3.
    function automatic logic [1:0] chk_bits(input logic [1:0] r);
        logic [1:0] c;
        case (r)
            2'd1:    c = 2'b10;
            2'd2:    c = 2'b01;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    assign ready = (state_q == IDLE) ||
                   ((state_q == CHK) && (cnt_q == CW'(1)));
    assign accept = ready && link.in_valid && !rst;
    assign chk = chk_bits(r_q);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        bit_d   = 1'b0;
        vld_d   = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        case (state_q)
            IDLE: ;
            DATA: begin
                vld_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = CHK;
                    cnt_d   = '0;
                    bit_d   = chk[1];
                end else begin
                    bit_d  = sreg_q[DATA_W-1];
                    sreg_d = sreg_q << 1;
                    r_d    = res_step(r_q, sreg_q[DATA_W-1]);
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            CHK: begin
                if (cnt_q == '0) begin
                    bit_d = chk[0];
                    vld_d = 1'b1;
                    eof_d = 1'b1;
                    cnt_d = CW'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new word overrides the idle/return path for gapless frames.
        if (accept) begin
            state_d = DATA;
            cnt_d   = '0;
            bit_d   = link.in_data[DATA_W-1];
            sreg_d  = link.in_data << 1;
            r_d     = res_step(2'd0, link.in_data[DATA_W-1]);
            vld_d   = 1'b1;
            sof_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            r_q     <= 2'd0;
            bit_q   <= 1'b0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            bit_q   <= bit_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    assign link.in_ready    = ready && !rst;
    assign link.bit_out     = bit_q;
    assign link.bit_valid   = vld_q;
    assign link.frame_start = sof_q;
    assign link.frame_end   = eof_q;
endmodule
